// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_ACK,
      S_GAP,
      S_DONE,
      S_ERROR
   } rst_seq_state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int h, input int g, input int t);
      int m;
      m = h;
      if (g > m) m = g;
      if (t > m) m = t;
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/cyc_cnt.sv
// Loadable saturating down-counter shared by the hold, gap and timeout phases.
module cyc_cnt #(
   parameter int W = 4
) (
   input  logic         clk_,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk_) begin
      if (clr)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (dec && (value != '0))
         value <= value - 1'b1;
   end

   assign zero = (value == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Releases N_CH reset domains one at a time after a hold period, waiting for
// each channel's ready acknowledge (with timeout) plus a gap between stages.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int HOLD_CYCLES = 5,
   parameter int STAGE_GAP   = 5,
   parameter int ACK_TIMEOUT = 1000,
   localparam int CH_W       = ch_w(N_CH)
) (
   input  logic            clk_,
   input  logic            rst,
   input  logic            sw_rst_req,
   input  logic [N_CH-1:0] ch_ready,
   output logic [N_CH-1:0] ch_rst,
   output logic            seq_done,
   output logic            timeout_err,
   output logic [CH_W-1:0] timeout_ch
);

   localparam int CNT_W = cnt_w(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
   localparam logic [CH_W-1:0]  LAST    = CH_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_GAP);
   localparam logic [CNT_W-1:0] ACK_LD  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   rst_seq_state_e  state, state_n;
   logic [CH_W-1:0] k, k_n;
   logic [N_CH-1:0] ch_rst_n;
   logic            armed, armed_n;
   logic            cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_val, cnt_value;
   logic            err_set, rel;

   cyc_cnt #(.W(CNT_W)) u_cnt (
      .clk_     (clk_),
      .clr      (rst | sw_rst_req),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .value    (cnt_value),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_n  = state;
      k_n      = k;
      ch_rst_n = ch_rst;
      armed_n  = armed;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      err_set  = 1'b0;
      rel      = 1'b0;
      case (state)
         // The counter comes out of reset at zero, so the first hold cycle arms it.
         S_HOLD: begin
            if (!armed && (HOLD_CYCLES > 1)) begin
               cnt_load = 1'b1;
               cnt_val  = HOLD_LD;
               armed_n  = 1'b1;
            end else if (!armed || (cnt_value == '0)) begin
               rel = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (ch_ready[k]) begin
               if (k == LAST) begin
                  state_n = S_DONE;
               end else begin
                  state_n  = S_GAP;
                  cnt_load = 1'b1;
                  cnt_val  = GAP_LD;
               end
            end else if (cnt_zero) begin
               state_n = S_ERROR;
               err_set = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_zero) begin
               k_n = k + CH_W'(1);
               rel = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: ;
      endcase

      // Without an acknowledge wait, the release edge itself counts as the acknowledge.
      if (rel) begin
         ch_rst_n[k_n] = 1'b0;
         if (ACK_TIMEOUT == 0) begin
            if (k_n == LAST) begin
               state_n = S_DONE;
            end else begin
               state_n  = S_GAP;
               cnt_load = 1'b1;
               cnt_val  = GAP_LD;
            end
         end else begin
            state_n  = S_WAIT_ACK;
            cnt_load = 1'b1;
            cnt_val  = ACK_LD;
         end
      end
   end

   always_ff @(posedge clk_) begin
      if (rst || sw_rst_req) begin
         state       <= S_HOLD;
         k           <= '0;
         armed       <= 1'b0;
         ch_rst      <= '1;
         seq_done    <= 1'b0;
         timeout_err <= 1'b0;
         timeout_ch  <= '0;
      end else begin
         state  <= state_n;
         k      <= k_n;
         armed  <= armed_n;
         ch_rst <= ch_rst_n;
         if (state == S_DONE)
            seq_done <= 1'b1;
         if (err_set) begin
            timeout_err <= 1'b1;
            timeout_ch  <= k;
         end
      end
   end

endmodule
